// File: rtl/nic_inject_flitizer.sv
// nic_inject_flitizer: splits one core packet into flits for a deflection router.
// Define INJ_STARVE_REQ_EN to build the injection starvation flag.
module nic_inject_flitizer #(
  parameter int DATA_W       = 32,
  parameter int MAX_FLITS    = 4,
  parameter int PKT_ID_W     = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [5:0]                      req_dst,
  input  logic [$clog2(MAX_FLITS)-1:0]    req_len,
  input  logic [MAX_FLITS*DATA_W-1:0]     req_data,
  input  logic                            slot_free,
  output logic                            flit_valid,
  output logic [5:0]                      flit_dst,
  output logic [PKT_ID_W-1:0]             flit_pkt_id,
  output logic [$clog2(MAX_FLITS)-1:0]    flit_seq,
  output logic                            flit_tail,
  output logic [DATA_W-1:0]               flit_data,
  output logic                            busy,
  output logic                            inj_starve
);

  localparam int LEN_W = $clog2(MAX_FLITS);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_nxt;

  logic [5:0]          dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    seq_q;
  logic [PKT_ID_W-1:0] id_q;
  logic [PKT_ID_W-1:0] id_ctr;
  logic [DATA_W-1:0]   word_q [MAX_FLITS];

  logic accept;
  logic inject;
  logic last;

  assign accept = (state == IDLE) && req_valid;
  assign inject = (state == SEND) && slot_free;
  assign last   = (seq_q == len_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (slot_free && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // packet capture, id counter and flit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q  <= '0;
      len_q  <= '0;
      seq_q  <= '0;
      id_q   <= '0;
      id_ctr <= '0;
      for (int i = 0; i < MAX_FLITS; i++) word_q[i] <= '0;
    end else if (accept) begin
      dst_q  <= req_dst;
      len_q  <= req_len;
      seq_q  <= '0;
      id_q   <= id_ctr;
      id_ctr <= id_ctr + PKT_ID_W'(1);
      for (int i = 0; i < MAX_FLITS; i++)
        word_q[i] <= req_data[i*DATA_W +: DATA_W];
    end else if (inject) begin
      seq_q <= seq_q + LEN_W'(1);
    end
  end

  // registered flit towards the router local port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_valid  <= 1'b0;
      flit_dst    <= '0;
      flit_pkt_id <= '0;
      flit_seq    <= '0;
      flit_tail   <= 1'b0;
      flit_data   <= '0;
    end else begin
      flit_valid <= inject;
      if (inject) begin
        flit_dst    <= dst_q;
        flit_pkt_id <= id_q;
        flit_seq    <= seq_q;
        flit_tail   <= last;
        flit_data   <= word_q[seq_q];
      end
    end
  end

`ifdef INJ_STARVE_REQ_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;

  // saturating count of blocked cycles while holding a packet
  always_comb begin
    starve_nxt = '0;
    if (state == SEND && !slot_free)
      starve_nxt = (starve_cnt >= LIMIT) ? starve_cnt
                                         : starve_cnt + SC_W'(1);
  end

  // counter and registered flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      inj_starve <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      inj_starve <= (starve_nxt >= LIMIT);
    end
  end
`else
  assign inj_starve = 1'b0;
`endif

endmodule

// File: tb/tb_nic_inject_flitizer.sv
// tb_nic_inject_flitizer: directed vectors for the injection flitizer.
// Starvation expectations follow INJ_STARVE_REQ_EN.
module tb_nic_inject_flitizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_dst;
  logic [1:0]   req_len;
  logic [127:0] req_data;
  logic         slot_free;
  logic         flit_valid;
  logic [5:0]   flit_dst;
  logic [3:0]   flit_pkt_id;
  logic [1:0]   flit_seq;
  logic         flit_tail;
  logic [31:0]  flit_data;
  logic         busy;
  logic         inj_starve;

  int tests = 0;
  int fails = 0;

  nic_inject_flitizer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dst     (req_dst),
    .req_len     (req_len),
    .req_data    (req_data),
    .slot_free   (slot_free),
    .flit_valid  (flit_valid),
    .flit_dst    (flit_dst),
    .flit_pkt_id (flit_pkt_id),
    .flit_seq    (flit_seq),
    .flit_tail   (flit_tail),
    .flit_data   (flit_data),
    .busy        (busy),
    .inj_starve  (inj_starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         req;
    logic [5:0] dst;
    logic [1:0] len;
    logic       sf;
    bit         ev;
    logic [1:0] eseq;
    bit         etail;
    int         eid;
    bit         erdy;
    bit         ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit req, input logic [5:0] dst,
                      input logic [1:0] len, input logic sf,
                      input bit ev, input logic [1:0] eseq,
                      input bit etail, input int eid,
                      input bit erdy, input bit ebusy);
    vec_t v;
    v.req = req; v.dst = dst; v.len = len; v.sf = sf;
    v.ev = ev; v.eseq = eseq; v.etail = etail; v.eid = eid;
    v.erdy = erdy; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] pw(input int id, input int i);
    return 32'hD000_0000 | 32'(id << 8) | 32'(i);
  endfunction

  function automatic logic [127:0] pkt_data(input int id);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = pw(id, i);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    req_dst   = '0;
    req_len   = '0;
    req_data  = '0;
  endtask

  bit starve_en;

  initial begin
`ifdef INJ_STARVE_REQ_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    // pkt 0: dst (x3,y5), len 3, slot always free
    addv(1, 6'h2B, 3, 1, 0, 0, 0, 0, 0, 1);
    addv(0, 6'h2B, 3, 1, 1, 0, 0, 0, 0, 1);
    addv(0, 6'h2B, 3, 1, 1, 1, 0, 0, 0, 1);
    addv(0, 6'h2B, 3, 1, 1, 2, 0, 0, 0, 1);
    addv(0, 6'h2B, 3, 1, 1, 3, 1, 0, 1, 0);
    addv(0, 6'h2B, 3, 1, 0, 0, 0, 0, 1, 0);
    // pkt 1: dst (1,1), len 0
    addv(1, 6'h09, 0, 1, 0, 0, 0, 1, 0, 1);
    addv(0, 6'h09, 0, 1, 1, 0, 1, 1, 1, 0);
    addv(0, 6'h09, 0, 1, 0, 0, 0, 1, 1, 0);
    // pkt 2: len 3, slot pattern 1,0,0,1,1,0,1
    addv(1, 6'h12, 3, 0, 0, 0, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 1, 1, 0, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 0, 0, 0, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 0, 0, 0, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 1, 1, 1, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 1, 1, 2, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 0, 0, 0, 0, 2, 0, 1);
    addv(0, 6'h12, 3, 1, 1, 3, 1, 2, 1, 0);
    addv(0, 6'h12, 3, 1, 0, 0, 0, 2, 1, 0);

    // reset state
    rst_n = 1'b0;
    slot_free = 1'b0;
    idle_in();
    #1;
    chk("rst ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst valid", flit_valid, 0);
    chk("rst data", flit_data, 0);
    chk("rst starve", inj_starve, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // table-driven packets
    foreach (vecs[k]) begin
      req_valid = vecs[k].req;
      req_dst   = vecs[k].req ? vecs[k].dst : 6'h0;
      req_len   = vecs[k].req ? vecs[k].len : 2'h0;
      req_data  = vecs[k].req ? pkt_data(vecs[k].eid) : 128'h0;
      slot_free = vecs[k].sf;
      step();
      chk($sformatf("v%0d valid", k), flit_valid, vecs[k].ev);
      chk($sformatf("v%0d ready", k), req_ready, vecs[k].erdy);
      chk($sformatf("v%0d busy", k), busy, vecs[k].ebusy);
      chk($sformatf("v%0d starve", k), inj_starve, 0);
      if (vecs[k].ev) begin
        chk($sformatf("v%0d seq", k), flit_seq, vecs[k].eseq);
        chk($sformatf("v%0d tail", k), flit_tail, vecs[k].etail);
        chk($sformatf("v%0d id", k), flit_pkt_id, vecs[k].eid);
        chk($sformatf("v%0d dst", k), flit_dst, vecs[k].dst);
        chk($sformatf("v%0d data", k), flit_data,
            pw(vecs[k].eid, int'(vecs[k].eseq)));
      end
    end
    idle_in();

    // reset in the middle of pkt 3 after seq 1
    req_valid = 1'b1;
    req_dst   = 6'h24;
    req_len   = 2'd3;
    req_data  = pkt_data(3);
    slot_free = 1'b1;
    step();
    idle_in();
    step();
    step();
    chk("mid seq1", flit_seq, 1);
    chk("mid id3", flit_pkt_id, 3);
    rst_n = 1'b0;
    #1;
    chk("mrst valid", flit_valid, 0);
    chk("mrst seq", flit_seq, 0);
    chk("mrst data", flit_data, 0);
    chk("mrst id", flit_pkt_id, 0);
    chk("mrst busy", busy, 0);
    chk("mrst ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post rst valid %0d", i), flit_valid, 0);
      chk($sformatf("post rst ready %0d", i), req_ready, 1);
    end

    // 17 back-to-back single-flit packets
    req_valid = 1'b1;
    req_dst   = 6'h3F;
    req_len   = 2'd0;
    slot_free = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req_data = pkt_data(k);
      step();
      chk($sformatf("b2b%0d ready lo", k), req_ready, 0);
      chk($sformatf("b2b%0d gap", k), flit_valid, 0);
      step();
      chk($sformatf("b2b%0d valid", k), flit_valid, 1);
      chk($sformatf("b2b%0d id", k), flit_pkt_id, k % 16);
      chk($sformatf("b2b%0d tail", k), flit_tail, 1);
      chk($sformatf("b2b%0d data", k), flit_data, pw(k, 0));
      chk($sformatf("b2b%0d ready hi", k), req_ready, 1);
    end
    idle_in();

    // starvation: 20 blocked edges then injection
    req_valid = 1'b1;
    req_dst   = 6'h01;
    req_len   = 2'd1;
    req_data  = pkt_data(1);
    slot_free = 1'b0;
    step();
    idle_in();
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("starve %0d", n), inj_starve, starve_en && n >= 15);
      chk($sformatf("blk valid %0d", n), flit_valid, 0);
    end
    slot_free = 1'b1;
    step();
    chk("starve clr", inj_starve, 0);
    chk("starve flit", flit_valid, 1);
    chk("starve seq", flit_seq, 0);
    chk("starve id", flit_pkt_id, 1);
    step();
    chk("starve tail", flit_tail, 1);
    chk("starve seq1", flit_seq, 1);
    chk("starve done", req_ready, 1);
    step();
    chk("starve idle", flit_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
